// File: rtl/top_level.sv
// Purpose: LFSR decryption engine; recovers taps and seed from the space preamble, decrypts a 64-byte message from DM.
// Latency: a run takes about 300 cycles or less from the req falling edge to ack (9x9 tap search, scan, 2 cycles per byte).
// Backpressure: none; req high holds the engine idle or abandons a run, and ack holds until req or init is raised.

// Single-port byte memory with combinational read; contents are deliberately not reset.
module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdat,
   output logic [7:0] rdat
);
   logic [7:0] core [0:255];

   // one write per cycle, no reset so a preloaded image survives init
   always_ff @(posedge clk) begin
      if (we) core[addr] <= wdat;
   end

   assign rdat = core[addr];
endmodule

module top_level #(
   parameter int MSG_BASE = 64,
   parameter int OUT_BASE = 0,
   parameter int MIN_PRE  = 10
) (
   input  logic clk,
   input  logic init,
   input  logic req,
   output logic ack
);
   typedef enum logic [2:0] {IDLE, SEED, SEARCH, SCAN, DECRYPT, DONE} state_t;

   state_t     state, state_nxt;
   logic [6:0] seed, seed_nxt;          // L[0], recovered from the first preamble byte
   logic [6:0] lfsr, lfsr_nxt;          // keystream value for the byte at idx
   logic [3:0] pat, pat_nxt;            // index into the legal tap table
   logic [6:0] idx, idx_nxt;            // message byte index (0..64)
   logic [6:0] oidx, oidx_nxt;          // output byte index (0..64)
   logic       wr_phase, wr_phase_nxt;  // decrypt: 0 = read/decode, 1 = write back
   logic [7:0] out_byte, out_byte_nxt;

   logic [7:0] mem_addr;
   logic [7:0] mem_wdat;
   logic [7:0] mem_rdat;
   logic       mem_we;

   logic [6:0] taps;
   logic [6:0] l_step;
   logic [6:0] dec;
   logic       par_ok;

   data_mem DM (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .wdat (mem_wdat),
      .rdat (mem_rdat)
   );

   function automatic logic [6:0] tap_pattern(input logic [3:0] p);
      case (p)
         4'd0:    return 7'h60;
         4'd1:    return 7'h48;
         4'd2:    return 7'h78;
         4'd3:    return 7'h72;
         4'd4:    return 7'h6A;
         4'd5:    return 7'h69;
         4'd6:    return 7'h5C;
         4'd7:    return 7'h7E;
         default: return 7'h7B;
      endcase
   endfunction

   assign taps   = tap_pattern(pat);
   assign l_step = {lfsr[5:0], ^(lfsr & taps)};
   assign dec    = mem_rdat[6:0] ^ lfsr;
   assign par_ok = ~(^mem_rdat);
   assign ack    = (state == DONE);

   // state and datapath registers; init clears control state but never memory
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state    <= IDLE;
         seed     <= '0;
         lfsr     <= '0;
         pat      <= '0;
         idx      <= '0;
         oidx     <= '0;
         wr_phase <= 1'b0;
         out_byte <= '0;
      end else begin
         state    <= state_nxt;
         seed     <= seed_nxt;
         lfsr     <= lfsr_nxt;
         pat      <= pat_nxt;
         idx      <= idx_nxt;
         oidx     <= oidx_nxt;
         wr_phase <= wr_phase_nxt;
         out_byte <= out_byte_nxt;
      end
   end

   // next-state, datapath updates and memory port control
   always_comb begin
      state_nxt    = state;
      seed_nxt     = seed;
      lfsr_nxt     = lfsr;
      pat_nxt      = pat;
      idx_nxt      = idx;
      oidx_nxt     = oidx;
      wr_phase_nxt = wr_phase;
      out_byte_nxt = out_byte;
      mem_addr     = 8'(MSG_BASE) + {1'b0, idx};
      mem_we       = 1'b0;
      mem_wdat     = out_byte;

      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (!req) state_nxt = SEED;
         end
         SEED: begin
            // the preamble decodes to zero, so the first byte is the seed itself
            seed_nxt  = mem_rdat[6:0];
            lfsr_nxt  = mem_rdat[6:0];
            pat_nxt   = '0;
            idx_nxt   = 7'd1;
            state_nxt = SEARCH;
         end
         SEARCH: begin
            if (mem_rdat[6:0] == l_step) begin
               if (idx == 7'(MIN_PRE - 1)) begin
                  lfsr_nxt  = seed;
                  idx_nxt   = '0;
                  state_nxt = SCAN;
               end else begin
                  lfsr_nxt = l_step;
                  idx_nxt  = idx + 7'd1;
               end
            end else begin
               lfsr_nxt = seed;
               idx_nxt  = 7'd1;
               if (pat == 4'd8) begin
                  // no pattern fits the preamble: fall back to the first one
                  pat_nxt   = '0;
                  idx_nxt   = '0;
                  state_nxt = SCAN;
               end else begin
                  pat_nxt = pat + 4'd1;
               end
            end
         end
         SCAN: begin
            if (idx != 7'd64 && par_ok && dec == 7'd0) begin
               lfsr_nxt = l_step;
               idx_nxt  = idx + 7'd1;
            end else begin
               // idx now equals the leading-space count
               oidx_nxt     = '0;
               wr_phase_nxt = 1'b0;
               state_nxt    = DECRYPT;
            end
         end
         DECRYPT: begin
            if (idx == 7'd64) begin
               // message consumed: zero-fill the tail vacated by stripped spaces
               if (oidx == 7'd64) begin
                  state_nxt = DONE;
               end else begin
                  mem_addr = 8'(OUT_BASE) + {1'b0, oidx};
                  mem_we   = 1'b1;
                  mem_wdat = 8'h00;
                  oidx_nxt = oidx + 7'd1;
               end
            end else if (!wr_phase) begin
               out_byte_nxt = {~par_ok, dec};
               wr_phase_nxt = 1'b1;
            end else begin
               mem_addr     = 8'(OUT_BASE) + {1'b0, oidx};
               mem_we       = 1'b1;
               mem_wdat     = out_byte;
               oidx_nxt     = oidx + 7'd1;
               idx_nxt      = idx + 7'd1;
               lfsr_nxt     = l_step;
               wr_phase_nxt = 1'b0;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // req high abandons any run; bytes already written are left in place
      if (req) begin
         state_nxt = IDLE;
         mem_we    = 1'b0;
      end
   end
endmodule

// File: tb/tb_top_level.sv
// Purpose: self-checking bench for the LFSR decryption engine against an array-level reference model.
// Latency: each run is allowed 400 cycles from the req falling edge to ack.
// Backpressure: exercises req hold-off, mid-run abort and asynchronous init.
module tb_top_level;
   localparam int MSG_BASE = 64;
   localparam int OUT_BASE = 0;
   localparam int MIN_PRE  = 10;

   logic clk = 1'b0;
   logic init;
   logic req;
   logic ack;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] plain   [64];
   logic [7:0] enc     [64];
   logic [7:0] exp_out [64];
   int         exp_lead;

   top_level #(
      .MSG_BASE (MSG_BASE),
      .OUT_BASE (OUT_BASE),
      .MIN_PRE  (MIN_PRE)
   ) dut (
      .clk  (clk),
      .init (init),
      .req  (req),
      .ack  (ack)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] pat_of(input int p);
      case (p)
         0:       return 7'h60;
         1:       return 7'h48;
         2:       return 7'h78;
         3:       return 7'h72;
         4:       return 7'h6A;
         5:       return 7'h69;
         6:       return 7'h5C;
         7:       return 7'h7E;
         default: return 7'h7B;
      endcase
   endfunction

   function automatic logic [7:0] mem_rd(input int a);
      return dut.DM.core[a[7:0]];
   endfunction

   task automatic mem_wr(input int a, input logic [7:0] v);
      dut.DM.core[a[7:0]] = v;
   endtask

   // plaintext: pre spaces, then msg, padded with spaces to 64 bytes
   task automatic make_plain(input int pre, input string msg);
      for (int i = 0; i < 64; i++) plain[i] = 8'h20;
      for (int i = 0; i < msg.len() && pre + i < 64; i++) plain[pre + i] = msg[i];
   endtask

   task automatic encode(input logic [6:0] p, input logic [6:0] s);
      logic [6:0] l;
      logic [7:0] d;
      logic [6:0] v;
      l = s;
      for (int i = 0; i < 64; i++) begin
         d      = plain[i] - 8'h20;
         v      = d[6:0] ^ l;
         enc[i] = {^v, v};
         l      = {l[5:0], ^(l & p)};
      end
   endtask

   // reference: tap search over the encrypted array, keystream table, strip, decode, zero-fill
   task automatic model();
      logic [6:0] s, tp, l;
      logic [6:0] ks [64];
      bit         found, ok;
      s     = enc[0][6:0];
      tp    = pat_of(0);
      found = 1'b0;
      for (int p = 0; p < 9; p++) begin
         if (!found) begin
            l  = s;
            ok = 1'b1;
            for (int k = 1; k < MIN_PRE; k++) begin
               l = {l[5:0], ^(l & pat_of(p))};
               if (enc[k][6:0] != l) ok = 1'b0;
            end
            if (ok) begin
               found = 1'b1;
               tp    = pat_of(p);
            end
         end
      end
      l = s;
      for (int k = 0; k < 64; k++) begin
         ks[k] = l;
         l     = {l[5:0], ^(l & tp)};
      end
      exp_lead = 0;
      while (exp_lead < 64 && (^enc[exp_lead]) == 1'b0 && (enc[exp_lead][6:0] ^ ks[exp_lead]) == 7'd0)
         exp_lead++;
      for (int n = 0; n < 64; n++) begin
         if (n + exp_lead < 64) exp_out[n] = {^enc[n + exp_lead], enc[n + exp_lead][6:0] ^ ks[n + exp_lead]};
         else                   exp_out[n] = 8'h00;
      end
   endtask

   task automatic load();
      @(negedge clk);
      init = 1'b1;
      req  = 1'b1;
      #1;
      for (int i = 0; i < 64; i++) begin
         mem_wr(MSG_BASE + i, enc[i]);
         mem_wr(OUT_BASE + i, 8'hEE);
      end
      @(negedge clk);
      init = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(output int cyc, output bit done);
      @(negedge clk);
      req  = 1'b0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 450) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack === 1'b1) done = 1'b1;
      end
   endtask

   task automatic test_reset_handshake();
      int cyc;
      bit done, dropped;
      init = 1'b1;
      req  = 1'b1;
      make_plain(10, "A");
      encode(7'h60, 7'h01);
      model();
      for (int i = 0; i < 64; i++) begin
         mem_wr(MSG_BASE + i, enc[i]);
         mem_wr(OUT_BASE + i, 8'hEE);
      end
      #20 init = 1'b0;
      #1;
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: ack=%b required 0", ack); end
      n_checks++;
      if (mem_rd(MSG_BASE) !== 8'h81) begin n_fail++; $display("FAIL preload_kept: E[0]=%02h required 81", mem_rd(MSG_BASE)); end
      #9 req = 1'b0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 450) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack === 1'b1) done = 1'b1;
      end
      n_checks++;
      if (!done || cyc > 400) begin n_fail++; $display("FAIL first_latency: ack after %0d cycles (seen=%0b) required <= 400", cyc, done); end
      dropped = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ack !== 1'b1) dropped = 1'b1;
      end
      n_checks++;
      if (dropped) begin n_fail++; $display("FAIL ack_hold: ack dropped=1 required 0"); end
      n_checks++;
      if (mem_rd(OUT_BASE) !== 8'h21) begin n_fail++; $display("FAIL first_out[0]: got %02h required 21", mem_rd(OUT_BASE)); end
      for (int n = 1; n < 64; n++) begin
         n_checks++;
         if (mem_rd(OUT_BASE + n) !== 8'h00) begin n_fail++; $display("FAIL first_out[%0d]: got %02h required 00", n, mem_rd(OUT_BASE + n)); end
      end
   endtask

   task automatic test_init_pulse();
      @(negedge clk);
      #2 init = 1'b1;
      #1;
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL init_async_ack: ack=%b required 0", ack); end
      req = 1'b1;
      #1 init = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL init_idle_ack: ack=%b required 0", ack); end
      for (int n = 0; n < 64; n++) begin
         n_checks++;
         if (mem_rd(OUT_BASE + n) !== exp_out[n]) begin n_fail++; $display("FAIL init_keep_out[%0d]: got %02h required %02h", n, mem_rd(OUT_BASE + n), exp_out[n]); end
         n_checks++;
         if (mem_rd(MSG_BASE + n) !== enc[n]) begin n_fail++; $display("FAIL init_keep_msg[%0d]: got %02h required %02h", n, mem_rd(MSG_BASE + n), enc[n]); end
      end
   endtask

   task automatic test_quote(input bit flips);
      int         cyc;
      bit         done;
      logic [7:0] want;
      logic [6:0] s;
      s = 7'($urandom_range(127, 1));
      make_plain(10, " Knowledge comes, but wisdom lingers.    ");
      encode(7'h7B, s);
      if (flips) for (int i = 24; i < 64; i++) enc[i][5] = ~enc[i][5];
      model();
      load();
      run(cyc, done);
      n_checks++;
      if (!done || cyc > 400) begin n_fail++; $display("FAIL quote_latency(flips=%0b): ack after %0d cycles (seen=%0b) required <= 400", flips, cyc, done); end
      for (int n = 0; n < 53; n++) begin
         want = plain[11 + n] - 8'h20;
         if (!flips || n < 13) begin
            n_checks++;
            if (mem_rd(OUT_BASE + n) !== want) begin n_fail++; $display("FAIL quote_text[%0d] (flips=%0b): got %02h required %02h", n, flips, mem_rd(OUT_BASE + n), want); end
         end else begin
            n_checks++;
            if (mem_rd(OUT_BASE + n) !== {1'b1, want[6] , ~want[5], want[4:0]}) begin n_fail++; $display("FAIL quote_flag[%0d]: got %02h required %02h", n, mem_rd(OUT_BASE + n), {1'b1, want[6], ~want[5], want[4:0]}); end
         end
      end
      for (int n = 0; n < 64; n++) begin
         n_checks++;
         if (mem_rd(OUT_BASE + n) !== exp_out[n]) begin n_fail++; $display("FAIL quote_model[%0d] (flips=%0b): got %02h required %02h", n, flips, mem_rd(OUT_BASE + n), exp_out[n]); end
      end
   endtask

   task automatic test_all_patterns();
      int         cyc;
      bit         done;
      logic [7:0] want [4];
      want[0] = 8'h21;
      want[1] = 8'h4A;
      want[2] = 8'h4F;
      want[3] = 8'h4B;
      for (int p = 0; p < 9; p++) begin
         make_plain(15, "Ajok");
         encode(pat_of(p), 7'h7F);
         model();
         load();
         run(cyc, done);
         n_checks++;
         if (!done || cyc > 400) begin n_fail++; $display("FAIL pattern%0d_latency: ack after %0d cycles (seen=%0b) required <= 400", p, cyc, done); end
         for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (mem_rd(OUT_BASE + n) !== want[n]) begin n_fail++; $display("FAIL pattern%0d_out[%0d]: got %02h required %02h", p, n, mem_rd(OUT_BASE + n), want[n]); end
         end
         for (int n = 4; n < 64; n++) begin
            n_checks++;
            if (mem_rd(OUT_BASE + n) !== exp_out[n]) begin n_fail++; $display("FAIL pattern%0d_tail[%0d]: got %02h required %02h", p, n, mem_rd(OUT_BASE + n), exp_out[n]); end
         end
      end
   endtask

   task automatic test_abort();
      int cyc, w;
      bit done, ack_seen, bad;
      make_plain(10, " Knowledge comes, but wisdom lingers.    ");
      encode(7'h60, 7'($urandom_range(127, 1)));
      model();
      load();
      @(negedge clk);
      req = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      req = 1'b1;
      ack_seen = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (ack !== 1'b0) ack_seen = 1'b1;
      end
      n_checks++;
      if (ack_seen) begin n_fail++; $display("FAIL abort_ack: ack seen=1 required 0"); end
      // a partial run leaves a correct prefix followed by untouched bytes
      w = 0;
      while (w < 64 && mem_rd(OUT_BASE + w) === exp_out[w]) w++;
      bad = 1'b0;
      for (int n = w; n < 64; n++) if (mem_rd(OUT_BASE + n) !== 8'hEE) bad = 1'b1;
      n_checks++;
      if (bad || w == 64) begin n_fail++; $display("FAIL abort_partial: prefix=%0d stray=%0b required prefix<64 stray=0", w, bad); end
      run(cyc, done);
      n_checks++;
      if (!done || cyc > 400) begin n_fail++; $display("FAIL restart_latency: ack after %0d cycles (seen=%0b) required <= 400", cyc, done); end
      for (int n = 0; n < 64; n++) begin
         n_checks++;
         if (mem_rd(OUT_BASE + n) !== exp_out[n]) begin n_fail++; $display("FAIL restart_out[%0d]: got %02h required %02h", n, mem_rd(OUT_BASE + n), exp_out[n]); end
      end
   endtask

   task automatic test_random();
      int         cyc, pre, len;
      bit         done;
      logic [6:0] p, s;
      for (int it = 0; it < 4; it++) begin
         pre = int'($urandom_range(20, 10));
         len = int'($urandom_range(64 - pre, 1));
         for (int i = 0; i < 64; i++) plain[i] = 8'h20;
         plain[pre] = 8'($urandom_range(8'h7E, 8'h21));
         for (int i = 1; i < len; i++) plain[pre + i] = 8'($urandom_range(8'h7E, 8'h20));
         p = pat_of(int'($urandom_range(8, 0)));
         s = 7'($urandom_range(127, 1));
         encode(p, s);
         for (int i = 24; i < 64; i++)
            if ($urandom_range(3, 0) == 0) enc[i][$urandom_range(7, 0)] ^= 1'b1;
         model();
         load();
         run(cyc, done);
         n_checks++;
         if (!done || cyc > 400) begin n_fail++; $display("FAIL random%0d_latency: ack after %0d cycles (seen=%0b) required <= 400", it, cyc, done); end
         for (int n = 0; n < 64; n++) begin
            n_checks++;
            if (mem_rd(OUT_BASE + n) !== exp_out[n]) begin n_fail++; $display("FAIL random%0d_out[%0d]: got %02h required %02h", it, n, mem_rd(OUT_BASE + n), exp_out[n]); end
         end
      end
   endtask

   initial begin
      test_reset_handshake();
      test_init_pulse();
      test_quote(1'b0);
      test_quote(1'b1);
      test_all_patterns();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/top_level.md
Name: top_level

Overview:
Hardwired decryption engine with an embedded 256-byte data memory. It reads a 64-byte LFSR-encrypted, parity-protected message from memory. It recovers the LFSR tap pattern and seed from the known space-padded preamble, then decrypts the message. Leading spaces are stripped, and each output byte carries a parity-error flag. The result is written back to low memory, and completion is signalled with ack.

Parameters:
MSG_BASE, 64, first address of the encrypted message (64 bytes, MSG_BASE..MSG_BASE+63).
OUT_BASE, 0, first address of the decrypted output.
MIN_PRE, 10, guaranteed minimum count of preamble space bytes.

Ports:
clk  input  1  single system clock, rising-edge.
init  input  1  asynchronous, active-high reset.
req  input  1  start request; high holds the engine idle, a falling edge launches a run.
ack  output  1  run complete.

Behaviour:
Memory
- Internal instance DM with array core[0:255] of 8 bits, hierarchically accessible as DM.core.
- The bench preloads DM.core while init is high; init must NOT clear memory.
- One read or write per cycle. Addresses 128..255 are scratch.

Encoding
- Encrypted byte i (E[i] = core[MSG_BASE+i]):
  - bit7 = even parity of bits 6:0 in the error-free case;
  - bits 6:0 = (char-0x20) XOR L[i].
- LFSR step: L[i+1] = {L[i][5:0], ^(L[i] & P)}.
- Legal P values, tried in this index order: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.

Reset and handshake
- init=1 forces state IDLE and ack=0.
- Run starts on the first clk edge with req=0 and init=0 while in IDLE.
- ack goes high after the final write and stays high until init or req is reasserted.
- req reasserted mid-run: the run is abandoned and the FSM returns to IDLE with ack=0. Written bytes stay.
- init mid-run: same as req, but asynchronous.

FSM: IDLE -> SEED -> SEARCH -> SCAN -> DECRYPT -> DONE.
- SEED: seed S = E[0][6:0], because the preamble character decodes to 0.
- SEARCH: for p = 0..8, regenerate L from S with P[p] and compare E[k][6:0] to L[k] for k=1..MIN_PRE-1.
  - Select the first p where all match.
  - If none matches, use p=0.
- SCAN: from i=0, count the leading bytes whose parity is correct and whose decoded value E[i][6:0]^L[i] == 0. This count is lead (0..64).
  - Scanning stops at the first nonzero decoded value or the first parity error.
  - Guaranteed input: lead <= 24, and bytes 0..23 are uncorrupted.
- DECRYPT: for i = lead..63, write core[OUT_BASE+i-lead]:
  - parity correct (^E[i][7:0] == 0): write {1'b0, E[i][6:0]^L[i]};
  - parity error: write {1'b1, E[i][6:0]^L[i]}.
  - Output values are char-0x20, i.e. space = 0x00.
- Output bytes beyond 63-lead (addresses 64-lead..63) are written 0x00.
- Latency: ack is asserted no later than 400 cycles after the run starts.

Test Plan:
- P=0x60, seed 0x01, pre 10 (10 space bytes), message "A", no corruption:
  - E[0] = 0x81.
  - core[0] = 0x21, core[1..53] = 0x00.
  - ack high within 400 cycles.
- P=0x7B, random seed, pre 10, message " Knowledge comes, but wisdom lingers.    ", no flips:
  - lead = 11.
  - core[0..52] == char-0x20 with bit7=0 ('K' -> 0x2B).
- Same message with bit 5 flipped in E[24..63]:
  - core[n] for n >= 13 has bit7 = 1.
  - core[0..12] decoded correctly with bit7 = 0.
- Each of the 9 patterns with seed 0x7F, pre 15, message "Ajok":
  - core[0..3] = 0x21, 0x4A, 0x4F, 0x4B in every case.
- Reset/handshake:
  - Preload memory under init = 1, release init at 20 ns, drop req at 30 ns.
  - ack = 0 until done, then stays 1.
  - Pulsing init clears ack immediately (asynchronously) and leaves memory contents unchanged.
- Mid-run abort: raise req 50 cycles into a run.
  - FSM returns to IDLE, ack stays 0.
  - Lowering req again restarts the run and completes with correct output.
